// File: rtl/seg7_pkg.sv
// Shared glyph constants and helpers for the multiplexed 7-segment driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ERR   = 7'b1111100;

  localparam logic [6:0] SEG_GLYPH [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Counter width for n states, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Nibble to active-low segment pattern, with blanking and the
// decimal-mode error glyph for codes above 9.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_GLYPH[code];
    unique case (1'b1)
      blank:                                seg_n = SEG_BLANK;
      (!blank && !hex_mode && code > 4'd9): seg_n = SEG_ERR;
      default:                              ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a shadow register
// copied to the display only at frame boundaries, and anode guard cycles.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    lzb,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    upd_pending
);

  localparam int IW = clog2(NUM_DIGITS);
  localparam int CW = clog2(REFRESH_DIV);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [4*NUM_DIGITS-1:0] shd_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   shd_dp;
  logic                    cnt_last;
  logic                    idx_last;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [3:0]              nib;
  logic [6:0]              glyph;

  assign cnt_last  = (cnt == CW'(REFRESH_DIV - 1));
  assign idx_last  = (idx == IW'(NUM_DIGITS - 1));
  assign frame_end = cnt_last && idx_last;
  assign nib       = disp_val[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
      if (cnt_last)
        idx <= idx_last ? '0 : idx + 1'b1;
    end
  end

  // A load on the boundary cycle goes straight to the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_val     <= '0;
      shd_dp      <= '0;
      disp_val    <= '0;
      disp_dp     <= '0;
      upd_pending <= 1'b0;
    end else begin
      if (load) begin
        shd_val <= value;
        shd_dp  <= dp_in;
      end
      if (frame_end && (upd_pending || load)) begin
        disp_val <= load ? value : shd_val;
        disp_dp  <= load ? dp_in : shd_dp;
      end
      upd_pending <= frame_end ? 1'b0 : (load || upd_pending);
    end
  end

  // A digit blanks when it and every digit to its left are zero.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc && (disp_val[4*i +: 4] == 4'd0);
      blank_vec[i] = lzb && acc && (i != 0);
    end
  end

  seg7_glyph_rom u_rom (
    .code     (nib),
    .hex_mode (hex_mode),
    .blank    (blank_vec[idx]),
    .seg_n    (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else begin
      seg_n <= glyph;
      dp_n  <= ~disp_dp[idx];
      an_n  <= (int'(cnt) >= GUARD) ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a tick-based reference model
// queues expected outputs, a negedge monitor pops and compares them.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int G  = 1;
  localparam int FL = N * RD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [15:0]  value = '0;
  logic [3:0]   dp_in = '0;
  logic         hex_mode = 1'b0;
  logic         lzb = 1'b0;
  logic [6:0]   seg_n;
  logic         dp_n;
  logic [3:0]   an_n;
  logic         upd_pending;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       upd;
  } exp_t;

  exp_t q[$];

  logic [6:0] gl [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          tick;
  logic [15:0] m_disp, m_shd;
  logic [3:0]  m_dpd, m_dps;
  logic        m_pend;

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .GUARD       (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .hex_mode    (hex_mode),
    .lzb         (lzb),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .upd_pending (upd_pending)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Reference model: digit slot and index derived from a cycle count.
  always @(posedge clk) begin
    if (rst) begin
      tick   = 0;
      m_disp = '0;
      m_shd  = '0;
      m_dpd  = '0;
      m_dps  = '0;
      m_pend = 1'b0;
      q.delete();
    end else begin
      exp_t e;
      int   slot, dig;
      logic [3:0] nb;
      bit   blank, boundary;
      slot  = tick % RD;
      dig   = (tick / RD) % N;
      nb    = 4'((m_disp >> (4 * dig)) & 16'hF);
      blank = lzb && dig > 0 && ((m_disp >> (4 * dig)) == 0);
      e.an  = (slot >= G) ? ~(4'b0001 << dig) : 4'hF;
      if (blank)
        e.seg = 7'b1111111;
      else if (!hex_mode && nb > 9)
        e.seg = 7'b1111100;
      else
        e.seg = gl[nb];
      e.dp = ~m_dpd[dig];
      boundary = (tick % FL) == FL - 1;
      if (boundary && (m_pend || load)) begin
        m_disp = load ? value : m_shd;
        m_dpd  = load ? dp_in : m_dps;
      end
      if (load) begin
        m_shd = value;
        m_dps = dp_in;
      end
      m_pend = boundary ? 1'b0 : (load || m_pend);
      e.upd  = m_pend;
      q.push_back(e);
      tick++;
    end
  end

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("seg_n", seg_n, e.seg);
      chk("dp_n", dp_n, e.dp);
      chk("an_n", an_n, e.an);
      chk("upd_pending", upd_pending, e.upd);
      chk("an_onehot", int'($countones(~an_n) <= 1), 1);
    end
  end

  task automatic wait_phase(input int ph);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FL && !found; i++) begin
      @(negedge clk);
      if (tick % FL == ph) found = 1'b1;
    end
    chk("phase_timeout", found, 1);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", an_n, 4'hF);
    chk("rst_seg", seg_n, 7'h7F);
    rst = 1'b0;
    run(FL);

    hex_mode = 1'b1;
    wait_phase(FL - 1);
    pulse_load(16'h12AF, 4'b0000);
    run(2 * FL);

    hex_mode = 1'b0;
    run(FL);

    lzb = 1'b1;
    wait_phase(FL - 1);
    pulse_load(16'h0050, 4'b0101);
    run(2 * FL);
    wait_phase(FL - 1);
    pulse_load(16'h0000, 4'b0000);
    run(2 * FL);

    wait_phase(RD + 1);
    pulse_load(16'h1111, 4'b0011);
    wait_phase(2 * RD + 1);
    pulse_load(16'h2222, 4'b1000);
    run(2 * FL);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: value = 16'($urandom);
        1: value = 16'($urandom) & 16'h00FF;
        2: value = 16'($urandom) & 16'h000F;
        default: value = 16'h0000;
      endcase
      dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 31) == 0) lzb = ~lzb;
    end
    load = 1'b0;

    wait_phase(RD + 2);
    pulse_load(16'h9876, 4'b1111);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", an_n, 4'hF);
    chk("arst_seg", seg_n, 7'h7F);
    chk("arst_dp", dp_n, 1);
    chk("arst_upd", upd_pending, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(3 * FL);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
